b_demodulator: RTL and testbench
================================

Name: b_demodulator

Overview:
- Receive-side counterpart of the 802.11b DBPSK/scrambler transmit chain.
- Takes hard-decision symbol bits, then DBPSK-decodes and self-synchronously descrambles them (x^7+x^4+1).
- Acquires SYNC (run of ones) and the SFD, then assembles payload bytes LSB-first with a valid strobe.
- Sits between the bit slicer and the frame parser.

Parameters:
SCRAMBLER_INIT_VAL, 7'h00, reset/clear value of the 7-bit descrambler shift register
DBPSK_INIT_VAL, 1'b0, reset/clear value of the previous-symbol register
SYNC_MIN_ONES, 32, consecutive descrambled ones required to declare SYNC
SFD_PATTERN, 16'hF3A0, SFD value; received bits shifted in LSB-first
SFD_TIMEOUT, 160, bits allowed in SFD_SEARCH before falling back to SYNC_SEARCH

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  synchronous enable; low clears all state to reset values
bit_valid  input  1  qualifies s_in for one clk
s_in  input  1  received DBPSK symbol bit
payload_len  input  12  payload byte count, sampled on the SFD match cycle
data_out  output  8  assembled payload byte, LSB = first received bit
byte_valid  output  1  one-clk strobe, data_out valid
sfd_found  output  1  one-clk strobe on SFD match
frame_done  output  1  one-clk strobe after the last payload byte
busy  output  1  high in SFD_SEARCH and PAYLOAD

Behaviour:
- Reset state (rst_n low, async; or enable low at a clk edge, sync):
  - descrambler = SCRAMBLER_INIT_VAL, prev = DBPSK_INIT_VAL.
  - State = SYNC_SEARCH; all counters 0.
  - data_out = 0; byte_valid, sfd_found, frame_done, busy = 0.
- Processing happens only on clk edges with enable & bit_valid. Other cycles hold all state; strobes are 0.
- Per accepted bit:
  - d = s_in ^ prev; prev <= s_in.
  - x = d ^ sr[3] ^ sr[6]; sr <= {sr[5:0], d}. The shift register takes the received scrambled bit, so it self-synchronises after 7 bits.
  - The descrambler and prev are never cleared at frame boundaries, only by reset or enable low.
- SYNC_SEARCH:
  - ones_cnt increments on x=1 and clears on x=0; it saturates at SYNC_MIN_ONES.
  - When the accepted bit makes ones_cnt reach SYNC_MIN_ONES: go to SFD_SEARCH, clear sfd_sr and bit_cnt.
- SFD_SEARCH:
  - sfd_sr <= {x, sfd_sr[15:1]}; bit_cnt increments.
  - If the updated sfd_sr == SFD_PATTERN: pulse sfd_found next cycle, latch payload_len into len_r, go to PAYLOAD, clear byte_cnt and the bit index.
  - Else if bit_cnt reaches SFD_TIMEOUT: go to SYNC_SEARCH with ones_cnt = 0.
  - A match on the same bit as the timeout wins.
  - Continued ones in this state are expected and do not restart anything.
- PAYLOAD:
  - shreg <= {x, shreg[7:1]}; a 3-bit index counts bits.
  - On the 8th bit: data_out <= the completed byte and byte_valid = 1 on the following cycle; byte_cnt increments.
  - When byte_cnt reaches len_r: frame_done pulses in the same cycle as that byte_valid, and the state goes to SYNC_SEARCH with ones_cnt = 0.
  - len_r == 0: frame_done pulses the cycle after sfd_found (no bytes emitted), then SYNC_SEARCH.
- Latency: every output strobe is registered and appears the clk after the accepting edge.
- data_out holds its last value between strobes.
- busy follows the registered state: 1 in SFD_SEARCH and PAYLOAD, 0 otherwise.
- enable low or rst_n low mid-frame aborts immediately. No frame_done is issued, and a partial byte is discarded.
- Back-to-back bit_valid on every clk must be supported; there is no back-pressure.

Test Plan:
- Clean frame: build it with a bench TX model (same scrambler, init 7'h00, DBPSK init 0) carrying 128 ones, SFD F3A0, payload_len=4, bytes A5 3C 00 FF, bit_valid every clk -> one sfd_found; byte_valid x4 with data A5,3C,00,FF; frame_done coincident with the FF strobe; busy returns to 0.
- Self-sync: TX scrambler seeded 7'h5B, RX seeded 7'h00, same frame with 64 ones -> SYNC acquired after the garbage bits settle; payload bytes correct.
- Gapped input: same frame with bit_valid 1-in-3 and random idle gaps -> identical byte sequence; no strobe ever on a non-accept cycle +1.
- SFD timeout: 64 ones then 200 ones with no SFD -> no sfd_found; busy drops after 160 SFD-search bits; then a valid SFD frame is received correctly.
- Mid-frame abort: deassert enable after 2 of 4 payload bytes for 1 clk, then resend the frame -> no frame_done for the first frame; second frame decoded fully. Repeat with a 1-cycle rst_n pulse, checking outputs go to 0 asynchronously.
- payload_len=0 -> sfd_found then frame_done on the next clk; no byte_valid.

Source files
------------

// File: rtl/b_demodulator_if.sv
// Bit-slicer to demodulator handshake plus the byte/strobe outputs toward the frame parser.
interface b_demodulator_if;
  logic        bit_valid;
  logic        s_in;
  logic [11:0] payload_len;
  logic [7:0]  data_out;
  logic        byte_valid;
  logic        sfd_found;
  logic        frame_done;
  logic        busy;

  modport master (
    output bit_valid, s_in, payload_len,
    input  data_out, byte_valid, sfd_found, frame_done, busy
  );

  modport slave (
    input  bit_valid, s_in, payload_len,
    output data_out, byte_valid, sfd_found, frame_done, busy
  );
endinterface

// File: rtl/b_demodulator.sv
// 802.11b receive chain: DBPSK decode, x^7+x^4+1 self-sync descramble,
// SYNC/SFD acquisition and LSB-first payload byte assembly.
module b_demodulator #(
  parameter logic [6:0]  SCRAMBLER_INIT_VAL = 7'h00,
  parameter logic        DBPSK_INIT_VAL     = 1'b0,
  parameter int          SYNC_MIN_ONES      = 32,
  parameter logic [15:0] SFD_PATTERN        = 16'hF3A0,
  parameter int          SFD_TIMEOUT        = 160
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  b_demodulator_if.slave   bus
);
  localparam int OW = $clog2(SYNC_MIN_ONES + 1);
  localparam int TW = $clog2(SFD_TIMEOUT + 1);
  localparam logic [OW-1:0] ONES_MAX = OW'(SYNC_MIN_ONES);
  localparam logic [TW-1:0] TMO_MAX  = TW'(SFD_TIMEOUT);

  typedef enum logic [1:0] {SYNC_SEARCH, SFD_SEARCH, PAYLOAD} state_t;

  state_t        state_q, state_d;
  logic [6:0]    sr_q, sr_d;
  logic          prev_q, prev_d;
  logic [OW-1:0] ones_q, ones_d;
  logic [TW-1:0] bcnt_q, bcnt_d;
  logic [15:0]   sfd_q, sfd_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    idx_q, idx_d;
  logic [11:0]   byte_cnt_q, byte_cnt_d;
  logic [11:0]   len_q, len_d;
  logic [7:0]    data_q, data_d;
  logic          bv_q, bv_d, sfdf_q, sfdf_d, fd_q, fd_d;

  logic        acc, d, x;
  logic [15:0] sfd_nxt;
  logic [7:0]  shreg_nxt;

  assign acc       = enable & bus.bit_valid;
  assign d         = bus.s_in ^ prev_q;
  assign x         = d ^ sr_q[3] ^ sr_q[6];
  assign sfd_nxt   = {x, sfd_q[15:1]};
  assign shreg_nxt = {x, shreg_q[7:1]};

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    prev_d     = prev_q;
    ones_d     = ones_q;
    bcnt_d     = bcnt_q;
    sfd_d      = sfd_q;
    shreg_d    = shreg_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    data_d     = data_q;
    bv_d       = 1'b0;
    sfdf_d     = 1'b0;
    fd_d       = 1'b0;
    // Descrambler taps the received (scrambled) bit, so it runs in every state.
    if (acc) begin
      prev_d = bus.s_in;
      sr_d   = {sr_q[5:0], d};
    end
    case (state_q)
      SYNC_SEARCH: if (acc) begin
        if (!x) begin
          ones_d = '0;
        end else if (ones_q + 1'b1 >= ONES_MAX) begin
          ones_d  = ONES_MAX;
          state_d = SFD_SEARCH;
          sfd_d   = '0;
          bcnt_d  = '0;
        end else begin
          ones_d = ones_q + 1'b1;
        end
      end
      SFD_SEARCH: if (acc) begin
        sfd_d  = sfd_nxt;
        bcnt_d = bcnt_q + 1'b1;
        if (sfd_nxt == SFD_PATTERN) begin
          sfdf_d     = 1'b1;
          len_d      = bus.payload_len;
          state_d    = PAYLOAD;
          byte_cnt_d = '0;
          idx_d      = '0;
        end else if (bcnt_q + 1'b1 == TMO_MAX) begin
          state_d = SYNC_SEARCH;
          ones_d  = '0;
        end
      end
      PAYLOAD: begin
        // Empty payload closes the frame on the next enabled edge, bit or not.
        if (len_q == '0) begin
          fd_d    = 1'b1;
          state_d = SYNC_SEARCH;
          ones_d  = '0;
        end else if (acc) begin
          shreg_d = shreg_nxt;
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
            data_d     = shreg_nxt;
            bv_d       = 1'b1;
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (byte_cnt_q + 1'b1 == len_q) begin
              fd_d    = 1'b1;
              state_d = SYNC_SEARCH;
              ones_d  = '0;
            end
          end
        end
      end
      default: state_d = SYNC_SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || !enable) begin
      state_q    <= SYNC_SEARCH;
      sr_q       <= SCRAMBLER_INIT_VAL;
      prev_q     <= DBPSK_INIT_VAL;
      ones_q     <= '0;
      bcnt_q     <= '0;
      sfd_q      <= '0;
      shreg_q    <= '0;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      data_q     <= '0;
      bv_q       <= 1'b0;
      sfdf_q     <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      prev_q     <= prev_d;
      ones_q     <= ones_d;
      bcnt_q     <= bcnt_d;
      sfd_q      <= sfd_d;
      shreg_q    <= shreg_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      data_q     <= data_d;
      bv_q       <= bv_d;
      sfdf_q     <= sfdf_d;
      fd_q       <= fd_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.byte_valid = bv_q;
  assign bus.sfd_found  = sfdf_q;
  assign bus.frame_done = fd_q;
  assign bus.busy       = (state_q != SYNC_SEARCH);
endmodule

// File: tb/tb_b_demodulator.sv
// Directed bench for b_demodulator: a TX scrambler/DBPSK model builds frames, a
// negedge monitor logs strobes and bytes, and all checks go through chk.
module tb_b_demodulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  b_demodulator_if bus();

  b_demodulator dut (.clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // TX model: scramble then differentially encode.
  logic [6:0] tsr = 7'h00;
  logic       tprev = 1'b0;
  logic [7:0] pl [4] = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
  logic [15:0] sfd_pat = 16'hF3A0;

  task automatic tx_sym(input logic b, output logic sym);
    logic s;
    s     = b ^ tsr[3] ^ tsr[6];
    tsr   = {tsr[5:0], s};
    sym   = tprev ^ s;
    tprev = sym;
  endtask

  // Monitor
  int cyc = 0;
  logic acc_q = 1'b0;
  logic busy_prev = 1'b0;
  int n_bv = 0, n_sfd = 0, n_fd = 0, n_fall = 0, bad_acc = 0;
  int sfd_cyc = 0, fd_cyc = 0;
  logic fd_bv = 1'b0;
  logic [7:0] bytes_q [$];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    acc_q <= enable & bus.bit_valid;
  end

  always @(negedge clk) begin
    busy_prev <= bus.busy;
    if (busy_prev && !bus.busy) n_fall <= n_fall + 1;
    if (bus.byte_valid) begin
      n_bv <= n_bv + 1;
      bytes_q.push_back(bus.data_out);
      if (!acc_q) bad_acc <= bad_acc + 1;
    end
    if (bus.sfd_found) begin
      n_sfd   <= n_sfd + 1;
      sfd_cyc <= cyc;
      if (!acc_q) bad_acc <= bad_acc + 1;
    end
    if (bus.frame_done) begin
      n_fd   <= n_fd + 1;
      fd_cyc <= cyc;
      fd_bv  <= bus.byte_valid;
    end
  end

  // Sends n_ones ones, SFD, then len bytes; stop>0 truncates after that many bits.
  task automatic send_frame(input int n_ones, input logic [11:0] len, input bit gapped, input int stop);
    logic bq [$];
    logic sym;
    int gap;
    bus.payload_len = len;
    for (int i = 0; i < n_ones; i++) bq.push_back(1'b1);
    for (int i = 0; i < 16; i++) bq.push_back(sfd_pat[i]);
    for (int by = 0; by < int'(len); by++)
      for (int bi = 0; bi < 8; bi++) bq.push_back(pl[by][bi]);
    for (int i = 0; i < bq.size(); i++) begin
      if (stop > 0 && i >= stop) break;
      tx_sym(bq[i], sym);
      bus.s_in      = sym;
      bus.bit_valid = 1'b1;
      @(posedge clk); #1;
      bus.bit_valid = 1'b0;
      gap = gapped ? 2 + int'($urandom_range(0, 3)) : 0;
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_frame(input string tag, input int base);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_byte%0d", tag, i), (base + i < bytes_q.size()) ? bytes_q[base + i] : 8'hxx, pl[i]);
  endtask

  int s_bv, s_sfd, s_fd, s_fall;

  initial begin
    bus.bit_valid   = 1'b0;
    bus.s_in        = 1'b0;
    bus.payload_len = 12'd0;
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_data", bus.data_out, 8'h00);
    chk("rst_bv", bus.byte_valid, 1'b0);
    chk("rst_sfd", bus.sfd_found, 1'b0);
    chk("rst_fd", bus.frame_done, 1'b0);
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Clean frame
    s_bv = n_bv; s_sfd = n_sfd; s_fd = n_fd;
    send_frame(128, 12'd4, 1'b0, 0);
    idle(5);
    chk("clean_sfd", n_sfd - s_sfd, 1);
    chk("clean_nbv", n_bv - s_bv, 4);
    chk_frame("clean", s_bv);
    chk("clean_fd", n_fd - s_fd, 1);
    chk("clean_fd_with_ff", fd_bv, 1'b1);
    chk("clean_busy", bus.busy, 1'b0);
    chk("clean_hold", bus.data_out, 8'hFF);

    // Self-sync: TX seeded differently from the RX register
    tsr = 7'h5B;
    s_bv = n_bv; s_fd = n_fd;
    send_frame(64, 12'd4, 1'b0, 0);
    idle(5);
    chk("ssync_nbv", n_bv - s_bv, 4);
    chk_frame("ssync", s_bv);
    chk("ssync_fd", n_fd - s_fd, 1);

    // Gapped input
    s_bv = n_bv; s_fd = n_fd;
    send_frame(128, 12'd4, 1'b1, 0);
    idle(5);
    chk("gap_nbv", n_bv - s_bv, 4);
    chk_frame("gap", s_bv);
    chk("gap_fd", n_fd - s_fd, 1);
    chk("gap_fd_with_ff", fd_bv, 1'b1);

    // SFD timeout
    s_bv = n_bv; s_sfd = n_sfd; s_fd = n_fd; s_fall = n_fall;
    send_frame(264, 12'd4, 1'b0, 264);
    idle(2);
    chk("tmo_no_sfd", n_sfd - s_sfd, 0);
    chk("tmo_busy_drop", n_fall - s_fall, 1);
    send_frame(64, 12'd4, 1'b0, 0);
    idle(5);
    chk("tmo_sfd", n_sfd - s_sfd, 1);
    chk("tmo_nbv", n_bv - s_bv, 4);
    chk_frame("tmo", s_bv);
    chk("tmo_fd", n_fd - s_fd, 1);

    // Abort with enable low
    s_bv = n_bv; s_fd = n_fd;
    send_frame(64, 12'd4, 1'b0, 64 + 16 + 16 + 3);
    idle(1);
    chk("en_ab_2bytes", n_bv - s_bv, 2);
    chk("en_ab_busy_pre", bus.busy, 1'b1);
    enable = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    tsr = 7'h00; tprev = 1'b0;
    chk("en_ab_busy", bus.busy, 1'b0);
    chk("en_ab_data", bus.data_out, 8'h00);
    idle(3);
    chk("en_ab_no_fd", n_fd - s_fd, 0);
    send_frame(64, 12'd4, 1'b0, 0);
    idle(5);
    chk("en_re_nbv", n_bv - s_bv, 6);
    chk("en_ab_b0", bytes_q[s_bv], 8'hA5);
    chk("en_ab_b1", bytes_q[s_bv + 1], 8'h3C);
    chk_frame("en_re", s_bv + 2);
    chk("en_re_fd", n_fd - s_fd, 1);

    // Abort with an async reset pulse
    s_bv = n_bv; s_fd = n_fd;
    send_frame(64, 12'd4, 1'b0, 64 + 16 + 16 + 3);
    chk("rst_ab_2bytes", n_bv - s_bv, 2);
    chk("rst_ab_busy_pre", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ab_busy", bus.busy, 1'b0);
    chk("rst_ab_data", bus.data_out, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tsr = 7'h00; tprev = 1'b0;
    idle(3);
    chk("rst_ab_no_fd", n_fd - s_fd, 0);
    send_frame(64, 12'd4, 1'b0, 0);
    idle(5);
    chk("rst_re_nbv", n_bv - s_bv, 6);
    chk_frame("rst_re", s_bv + 2);
    chk("rst_re_fd", n_fd - s_fd, 1);

    // payload_len = 0
    s_bv = n_bv; s_sfd = n_sfd; s_fd = n_fd;
    send_frame(64, 12'd0, 1'b0, 0);
    idle(5);
    chk("len0_sfd", n_sfd - s_sfd, 1);
    chk("len0_fd", n_fd - s_fd, 1);
    chk("len0_nbv", n_bv - s_bv, 0);
    chk("len0_fd_next", fd_cyc - sfd_cyc, 1);
    chk("len0_busy", bus.busy, 1'b0);

    chk("strobe_on_accept", bad_acc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
